// File: rtl/store_serializer_pkg.sv
// Shared CPU definitions for the store path: access-size encodings, the
// serializer state enum, and helpers for the byte count and alignment checks.
package store_serializer_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      DONE  = 2'b10,
      ERR   = 2'b11
   } state_e;

   // Index of the final byte lane (N-1) for an access size.
   function automatic logic [1:0] last_index(input size_e sz);
      case (sz)
         SZ_BYTE: last_index = 2'd0;
         SZ_HALF: last_index = 2'd1;
         default: last_index = 2'd3;
      endcase
   endfunction

   function automatic logic misaligned(input size_e sz, input logic [1:0] low);
      case (sz)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = low[0];
         SZ_WORD: misaligned = (low != 2'b00);
         default: misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/store_serializer.sv
// Serializes a byte/half/word store into little-endian byte writes, one per
// mem_ready handshake; all outputs decode from registered state only.
module store_serializer
   import store_serializer_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        size,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic              mem_ready,
   output logic              mem_en,
   output logic              rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        data_out,
   output logic [3:0]        byte_sel,
   output logic              busy,
   output logic              done,
   output logic              err
);

   // Handshake: a byte transfer is offered while mem_en=1 and is consumed on
   // the rising edge where mem_ready=1; until then every output holds steady.

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       data_q;
   size_e             size_q;
   logic [1:0]        k_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request capture and byte-index counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q <= '0;
         data_q <= '0;
         size_q <= SZ_BYTE;
         k_q    <= 2'd0;
      end else if (state_q == IDLE && start) begin
         base_q <= addr;
         data_q <= wdata;
         size_q <= size_e'(size);
         k_q    <= 2'd0;
      end else if (state_q == WRITE && mem_ready) begin
         k_q    <= k_q + 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = misaligned(size_e'(size), addr[1:0]) ? ERR : WRITE;
            end
         end
         WRITE: begin
            if (mem_ready && k_q == last_index(size_q)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_en   = 1'b0;
      rw       = 1'b0;
      mem_addr = '0;
      data_out = 8'h00;
      byte_sel = 4'b0000;
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      err      = (state_q == ERR);
      if (state_q == WRITE) begin
         mem_en   = 1'b1;
         rw       = 1'b1;
         mem_addr = base_q + {{(ADDR_W-2){1'b0}}, k_q};
         data_out = data_q[{k_q, 3'b000} +: 8];
         byte_sel = 4'b0001 << k_q;
      end
   end

endmodule

// File: tb/tb_store_serializer.sv
// Self-checking bench for store_serializer: directed scenarios plus random
// stores compared against a byte-list reference model.
module tb_store_serializer;

   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              mem_ready;
   logic              mem_en;
   logic              rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        data_out;
   logic [3:0]        byte_sel;
   logic              busy;
   logic              done;
   logic              err;

   int n_assert = 0;
   int n_fail   = 0;

   store_serializer #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .size      (size),
      .addr      (addr),
      .wdata     (wdata),
      .mem_ready (mem_ready),
      .mem_en    (mem_en),
      .rw        (rw),
      .mem_addr  (mem_addr),
      .data_out  (data_out),
      .byte_sel  (byte_sel),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({tag, ".rw"}, {31'd0, rw}, 32'd0);
      chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
      chk({tag, ".done"}, {31'd0, done}, 32'd0);
      chk({tag, ".err"}, {31'd0, err}, 32'd0);
      chk({tag, ".byte_sel"}, {28'd0, byte_sel}, 32'd0);
      chk({tag, ".mem_addr"}, {16'd0, mem_addr}, 32'd0);
      chk({tag, ".data_out"}, {24'd0, data_out}, 32'd0);
   endtask

   // Reference model: a store is the list of (address, byte, lane) writes it
   // must produce, or an error pulse if the request is misaligned.
   // mode 0: mem_ready always 1; mode 1: random; mode 2: two wait cycles per byte.
   task automatic run_store(input string tag, input logic [1:0] sz, input logic [15:0] a,
                            input logic [31:0] d, input int mode);
      logic [15:0] exp_a[$];
      logic [7:0]  exp_d[$];
      logic [3:0]  exp_s[$];
      logic [15:0] ak;
      bit          bad;
      int          n;
      int          waits;
      int          guard;
      logic        r;
      bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int k = 0; k < n; k++) begin
         ak = a + 16'(k);
         exp_a.push_back(ak);
         exp_d.push_back(8'((d >> (8 * k)) & 32'hFF));
         exp_s.push_back(4'(1 << k));
      end
      start = 1'b1; size = sz; addr = a; wdata = d; mem_ready = 1'b0;
      step();
      // Scramble the request inputs to prove they were captured.
      start = 1'b0; addr = 16'($urandom); wdata = $urandom; size = 2'($urandom_range(0, 3));
      if (bad) begin
         chk({tag, ".err"}, {31'd0, err}, 32'd1);
         chk({tag, ".err_mem_en"}, {31'd0, mem_en}, 32'd0);
         chk({tag, ".err_busy"}, {31'd0, busy}, 32'd1);
         step();
         chk_idle({tag, ".after_err"});
         return;
      end
      waits = 0;
      guard = 0;
      while (exp_a.size() > 0 && guard < 200) begin
         chk({tag, ".mem_en"}, {31'd0, mem_en}, 32'd1);
         chk({tag, ".rw"}, {31'd0, rw}, 32'd1);
         chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
         chk({tag, ".done_early"}, {31'd0, done}, 32'd0);
         chk({tag, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, exp_a[0]});
         chk({tag, ".data_out"}, {24'd0, data_out}, {24'd0, exp_d[0]});
         chk({tag, ".byte_sel"}, {28'd0, byte_sel}, {28'd0, exp_s[0]});
         case (mode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = (waits == 2);
         endcase
         mem_ready = r;
         step();
         if (r) begin
            void'(exp_a.pop_front());
            void'(exp_d.pop_front());
            void'(exp_s.pop_front());
            waits = 0;
         end else begin
            waits++;
         end
         guard++;
      end
      if (guard >= 200) begin
         n_assert++;
         n_fail++;
         $error("FAIL %s.timeout observed=%0d expected=<200 cycles", tag, guard);
      end
      mem_ready = 1'b0;
      chk({tag, ".done"}, {31'd0, done}, 32'd1);
      chk({tag, ".done_mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({tag, ".done_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".done_sel"}, {28'd0, byte_sel}, 32'd0);
      step();
      chk_idle({tag, ".after_done"});
   endtask

   initial begin
      int writes;
      int dones;
      logic [1:0]  rsz;
      logic [15:0] ra;
      reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; wdata = '0; mem_ready = 1'b0;
      step();
      start = 1'b1; mem_ready = 1'b1;
      step();
      chk_idle("reset");
      reset = 1'b0; start = 1'b0; mem_ready = 1'b0;
      step();
      chk_idle("post_reset");

      run_store("sw_deadbeef", 2'b10, 16'h0010, 32'hDEADBEEF, 0);
      run_store("sh_waits", 2'b01, 16'h0042, 32'h00001234, 2);
      run_store("sw_misaligned", 2'b10, 16'h0011, 32'h11223344, 0);
      run_store("sh_misaligned", 2'b01, 16'h0001, 32'h00005566, 0);
      run_store("size11", 2'b11, 16'h0020, 32'h77777777, 0);
      run_store("sb_wrap", 2'b00, 16'hFFFF, 32'h000000A5, 0);

      // Reset while the second byte of a word store is on the bus.
      start = 1'b1; size = 2'b10; addr = 16'h0100; wdata = 32'hCAFEF00D; mem_ready = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("rst_mid.byte2_addr", {16'd0, mem_addr}, 32'h0101);
      reset = 1'b1;
      step();
      reset = 1'b0; mem_ready = 1'b1;
      chk_idle("rst_mid");
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done || mem_en) dones++;
      end
      chk("rst_mid.no_activity", dones, 0);
      mem_ready = 1'b0;
      run_store("sb_after_reset", 2'b00, 16'h0005, 32'h0000007F, 0);

      // start held high through a whole word store.
      start = 1'b1; size = 2'b10; addr = 16'h0200; wdata = 32'h0A0B0C0D; mem_ready = 1'b1;
      writes = 0;
      dones = 0;
      step();
      for (int i = 0; i < 12 && !done; i++) begin
         if (mem_en) writes++;
         step();
      end
      if (done) dones++;
      chk("hold.writes", writes, 4);
      chk("hold.done_seen", dones, 1);
      step();
      chk("hold.idle_busy", {31'd0, busy}, 32'd0);
      chk("hold.idle_mem_en", {31'd0, mem_en}, 32'd0);
      step();
      start = 1'b0;
      chk("hold.second_accept", {31'd0, mem_en}, 32'd1);
      chk("hold.second_addr", {16'd0, mem_addr}, 32'h0200);
      for (int i = 0; i < 12 && busy; i++) step();
      chk("hold.drained", {31'd0, busy}, 32'd0);
      mem_ready = 1'b0;
      step();

      for (int t = 0; t < 40; t++) begin
         rsz = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         run_store("rand", rsz, ra, $urandom, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
